// File: rtl/trigger_pkg.sv
// rtl/trigger_pkg.sv - shared state encoding and sizing helper for the trigger sequencer
package trigger_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    FIRED = 2'd2,
    DELAY = 2'd3
  } trig_state_e;

  // Width of a stage index; a single-stage build still needs one bit.
  function automatic int stage_idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/trigger_stage_match.sv
// rtl/trigger_stage_match.sv - combinational level/edge match for one trigger stage
module trigger_stage_match #(
  parameter int SAMPLE_WIDTH = 8
) (
  input  logic                    valid,
  input  logic [SAMPLE_WIDTH-1:0] data_in,
  input  logic [SAMPLE_WIDTH-1:0] prev_sample,
  input  logic                    prev_ok,
  input  logic [SAMPLE_WIDTH-1:0] level_mask,
  input  logic [SAMPLE_WIDTH-1:0] level_value,
  input  logic [SAMPLE_WIDTH-1:0] rise,
  input  logic [SAMPLE_WIDTH-1:0] fall,
  output logic                    match
);

  logic [SAMPLE_WIDTH-1:0] edge_sel;
  logic [SAMPLE_WIDTH-1:0] ch_ok;
  logic                    level_ok;
  logic                    edge_ok;

  // AND of level compare and per-channel edge terms; a channel with both
  // rise and fall selected accepts either transition.
  always_comb begin
    edge_sel = rise | fall;
    ch_ok    = ~edge_sel
             | (rise & ~prev_sample &  data_in)
             | (fall &  prev_sample & ~data_in);
    level_ok = ((data_in ^ level_value) & level_mask) == '0;
    // Without a valid previous sample no edge can be claimed.
    edge_ok  = (&ch_ok) & (prev_ok | ~(|edge_sel));
    match    = valid & level_ok & edge_ok;
  end

endmodule

// File: rtl/trigger_sequencer.sv
// rtl/trigger_sequencer.sv - multi-stage trigger sequencer; optional post-trigger delay via TRIGGER_SEQ_DELAY_EN
module trigger_sequencer
  import trigger_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 8,
  parameter int STAGES       = 4,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           valid,
  input  logic [SAMPLE_WIDTH-1:0]        dataIn,
  input  logic                           arm,
  input  logic                           cfg_we,
  input  logic [stage_idx_w(STAGES)-1:0] cfg_stage,
  input  logic [SAMPLE_WIDTH-1:0]        cfg_level_mask,
  input  logic [SAMPLE_WIDTH-1:0]        cfg_level_value,
  input  logic [SAMPLE_WIDTH-1:0]        cfg_rise,
  input  logic [SAMPLE_WIDTH-1:0]        cfg_fall,
  input  logic [COUNT_WIDTH-1:0]         cfg_count,
  input  logic [stage_idx_w(STAGES)-1:0] cfg_last_stage,
`ifdef TRIGGER_SEQ_DELAY_EN
  input  logic [COUNT_WIDTH-1:0]         cfg_delay,
`endif
  output logic                           armed,
  output logic [stage_idx_w(STAGES)-1:0] stage,
  output logic                           run,
  output logic                           triggered
);

  localparam int STAGE_IDX_W = stage_idx_w(STAGES);

  logic [SAMPLE_WIDTH-1:0] lvl_mask_q  [STAGES];
  logic [SAMPLE_WIDTH-1:0] lvl_value_q [STAGES];
  logic [SAMPLE_WIDTH-1:0] rise_q      [STAGES];
  logic [SAMPLE_WIDTH-1:0] fall_q      [STAGES];
  logic [COUNT_WIDTH-1:0]  count_q     [STAGES];
  logic [STAGE_IDX_W-1:0]  last_q;

  trig_state_e             state_q, state_d;
  logic [STAGE_IDX_W-1:0]  stage_q, stage_d;
  logic [COUNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                    prev_ok_q, prev_ok_d;
  logic                    run_q, run_d;
  logic                    trig_q, trig_d;
  logic [SAMPLE_WIDTH-1:0] prev_sample_q;
  logic                    stage_match;
  logic                    cfg_ok;

`ifdef TRIGGER_SEQ_DELAY_EN
  logic [COUNT_WIDTH-1:0]  delay_q;
  logic [COUNT_WIDTH-1:0]  dleft_q, dleft_d;
`endif

  // Configuration is frozen while a sequence is in progress.
  assign cfg_ok = cfg_we && (state_q == IDLE || state_q == FIRED);

  // Stage configuration table and final-stage index.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < STAGES; i++) begin
        lvl_mask_q[i]  <= '0;
        lvl_value_q[i] <= '0;
        rise_q[i]      <= '0;
        fall_q[i]      <= '0;
        count_q[i]     <= '0;
      end
      last_q <= '0;
`ifdef TRIGGER_SEQ_DELAY_EN
      delay_q <= '0;
`endif
    end else if (cfg_ok) begin
      if (int'(cfg_stage) < STAGES) begin
        lvl_mask_q[cfg_stage]  <= cfg_level_mask;
        lvl_value_q[cfg_stage] <= cfg_level_value;
        rise_q[cfg_stage]      <= cfg_rise;
        fall_q[cfg_stage]      <= cfg_fall;
        count_q[cfg_stage]     <= cfg_count;
      end
      if (int'(cfg_last_stage) >= STAGES) begin
        last_q <= STAGE_IDX_W'(STAGES - 1);
      end else begin
        last_q <= cfg_last_stage;
      end
`ifdef TRIGGER_SEQ_DELAY_EN
      delay_q <= cfg_delay;
`endif
    end
  end

  // Previous sample for edge detection, refreshed on every valid cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prev_sample_q <= '0;
    end else if (valid) begin
      prev_sample_q <= dataIn;
    end
  end

  trigger_stage_match #(
    .SAMPLE_WIDTH(SAMPLE_WIDTH)
  ) u_match (
    .valid       (valid),
    .data_in     (dataIn),
    .prev_sample (prev_sample_q),
    .prev_ok     (prev_ok_q),
    .level_mask  (lvl_mask_q[stage_q]),
    .level_value (lvl_value_q[stage_q]),
    .rise        (rise_q[stage_q]),
    .fall        (fall_q[stage_q]),
    .match       (stage_match)
  );

  // Sequencer state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      stage_q   <= '0;
      cnt_q     <= '0;
      prev_ok_q <= 1'b0;
      run_q     <= 1'b0;
      trig_q    <= 1'b0;
`ifdef TRIGGER_SEQ_DELAY_EN
      dleft_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      stage_q   <= stage_d;
      cnt_q     <= cnt_d;
      prev_ok_q <= prev_ok_d;
      run_q     <= run_d;
      trig_q    <= trig_d;
`ifdef TRIGGER_SEQ_DELAY_EN
      dleft_q   <= dleft_d;
`endif
    end
  end

  // Next-state: arm wins over everything; otherwise count matches and walk stages.
  always_comb begin
    state_d   = state_q;
    stage_d   = stage_q;
    cnt_d     = cnt_q;
    prev_ok_d = prev_ok_q;
    run_d     = run_q;
    trig_d    = trig_q;
`ifdef TRIGGER_SEQ_DELAY_EN
    dleft_d   = dleft_q;
`endif
    if (arm) begin
      state_d   = ARMED;
      stage_d   = '0;
      cnt_d     = '0;
      prev_ok_d = 1'b0;
      run_d     = 1'b0;
      trig_d    = 1'b0;
    end else begin
      if (valid) begin
        prev_ok_d = 1'b1;
      end
      // run has now been seen alongside a valid sample.
      if (run_q && valid) begin
        run_d = 1'b0;
      end
      case (state_q)
        ARMED: begin
          if (stage_match) begin
            if (cnt_q != count_q[stage_q]) begin
              cnt_d = cnt_q + COUNT_WIDTH'(1);
            end else if (stage_q == last_q) begin
              trig_d = 1'b1;
`ifdef TRIGGER_SEQ_DELAY_EN
              if (delay_q != '0) begin
                state_d = DELAY;
                dleft_d = delay_q;
              end else begin
                state_d = FIRED;
                run_d   = 1'b1;
              end
`else
              state_d = FIRED;
              run_d   = 1'b1;
`endif
            end else begin
              stage_d = stage_q + STAGE_IDX_W'(1);
              cnt_d   = '0;
            end
          end
        end
`ifdef TRIGGER_SEQ_DELAY_EN
        DELAY: begin
          if (valid) begin
            if (dleft_q == COUNT_WIDTH'(1)) begin
              state_d = FIRED;
              run_d   = 1'b1;
            end else begin
              dleft_d = dleft_q - COUNT_WIDTH'(1);
            end
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign armed     = (state_q == ARMED);
  assign stage     = stage_q;
  assign run       = run_q;
  assign triggered = trig_q;

endmodule

// File: tb/tb_trigger_sequencer.sv
// tb/tb_trigger_sequencer.sv - directed self-checking bench for trigger_sequencer
module tb_trigger_sequencer;

  logic       clock;
  logic       reset_n;
  logic       valid;
  logic [7:0] dataIn;
  logic       arm;
  logic       cfg_we;
  logic [1:0] cfg_stage;
  logic [7:0] cfg_level_mask;
  logic [7:0] cfg_level_value;
  logic [7:0] cfg_rise;
  logic [7:0] cfg_fall;
  logic [15:0] cfg_count;
  logic [1:0] cfg_last_stage;
`ifdef TRIGGER_SEQ_DELAY_EN
  logic [15:0] cfg_delay;
`endif
  logic       armed;
  logic [1:0] stage;
  logic       run;
  logic       triggered;

  int total;
  int bad;

  trigger_sequencer #(
    .SAMPLE_WIDTH(8),
    .STAGES(4),
    .COUNT_WIDTH(16)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .valid           (valid),
    .dataIn          (dataIn),
    .arm             (arm),
    .cfg_we          (cfg_we),
    .cfg_stage       (cfg_stage),
    .cfg_level_mask  (cfg_level_mask),
    .cfg_level_value (cfg_level_value),
    .cfg_rise        (cfg_rise),
    .cfg_fall        (cfg_fall),
    .cfg_count       (cfg_count),
    .cfg_last_stage  (cfg_last_stage),
`ifdef TRIGGER_SEQ_DELAY_EN
    .cfg_delay       (cfg_delay),
`endif
    .armed           (armed),
    .stage           (stage),
    .run             (run),
    .triggered       (triggered)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic cyc();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic sample(input logic [7:0] d);
    valid  = 1'b1;
    dataIn = d;
    cyc();
    valid  = 1'b0;
  endtask

  task automatic arm_pulse();
    arm = 1'b1;
    cyc();
    arm = 1'b0;
  endtask

  task automatic cfg_write(input logic [1:0] s, input logic [7:0] lm, input logic [7:0] lv,
                           input logic [7:0] r, input logic [7:0] f, input logic [15:0] c,
                           input logic [1:0] last);
    cfg_we          = 1'b1;
    cfg_stage       = s;
    cfg_level_mask  = lm;
    cfg_level_value = lv;
    cfg_rise        = r;
    cfg_fall        = f;
    cfg_count       = c;
    cfg_last_stage  = last;
    cyc();
    cfg_we          = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    cyc();
    total++; if (armed !== 1'b0) begin bad++; $display("FAIL reset_armed got=%b want=0", armed); end
    total++; if (stage !== 2'd0) begin bad++; $display("FAIL reset_stage got=%0d want=0", stage); end
    total++; if (run !== 1'b0) begin bad++; $display("FAIL reset_run got=%b want=0", run); end
    total++; if (triggered !== 1'b0) begin bad++; $display("FAIL reset_triggered got=%b want=0", triggered); end
    reset_n = 1'b1;
    cyc();
  endtask

  task automatic test_level();
    cfg_write(2'd0, 8'hFF, 8'hA5, 8'h00, 8'h00, 16'd0, 2'd0);
    total++; if (armed !== 1'b0) begin bad++; $display("FAIL level_idle_armed got=%b want=0", armed); end
    arm_pulse();
    total++; if (armed !== 1'b1) begin bad++; $display("FAIL level_armed got=%b want=1", armed); end
    sample(8'h00);
    total++; if (run !== 1'b0) begin bad++; $display("FAIL level_nomatch_run got=%b want=0", run); end
    sample(8'hA5);
    total++; if (run !== 1'b1) begin bad++; $display("FAIL level_run got=%b want=1", run); end
    total++; if (triggered !== 1'b1) begin bad++; $display("FAIL level_triggered got=%b want=1", triggered); end
    total++; if (armed !== 1'b0) begin bad++; $display("FAIL level_fired_armed got=%b want=0", armed); end
    sample(8'h00);
    total++; if (run !== 1'b0) begin bad++; $display("FAIL level_run_clear got=%b want=0", run); end
    total++; if (triggered !== 1'b1) begin bad++; $display("FAIL level_sticky got=%b want=1", triggered); end
  endtask

  task automatic test_rise_count();
    cfg_write(2'd0, 8'h00, 8'h00, 8'h08, 8'h00, 16'd2, 2'd0);
    arm_pulse();
    sample(8'h00);
    sample(8'h08);
    total++; if (run !== 1'b0) begin bad++; $display("FAIL rise_edge1_run got=%b want=0", run); end
    total++; if (stage !== 2'd0) begin bad++; $display("FAIL rise_edge1_stage got=%0d want=0", stage); end
    sample(8'h00);
    sample(8'h08);
    total++; if (run !== 1'b0) begin bad++; $display("FAIL rise_edge2_run got=%b want=0", run); end
    total++; if (armed !== 1'b1) begin bad++; $display("FAIL rise_edge2_armed got=%b want=1", armed); end
    sample(8'h00);
    total++; if (run !== 1'b0) begin bad++; $display("FAIL rise_low_run got=%b want=0", run); end
    sample(8'h08);
    total++; if (run !== 1'b1) begin bad++; $display("FAIL rise_edge3_run got=%b want=1", run); end
    total++; if (stage !== 2'd0) begin bad++; $display("FAIL rise_edge3_stage got=%0d want=0", stage); end
  endtask

  task automatic test_two_stage();
    cfg_write(2'd0, 8'h01, 8'h01, 8'h00, 8'h00, 16'd0, 2'd1);
    cfg_write(2'd1, 8'h00, 8'h00, 8'h00, 8'h01, 16'd0, 2'd1);
    arm_pulse();
    total++; if (run !== 1'b0) begin bad++; $display("FAIL two_arm_run got=%b want=0", run); end
    sample(8'h00);
    total++; if (stage !== 2'd0) begin bad++; $display("FAIL two_early_stage got=%0d want=0", stage); end
    sample(8'h01);
    total++; if (stage !== 2'd1) begin bad++; $display("FAIL two_advance_stage got=%0d want=1", stage); end
    total++; if (run !== 1'b0) begin bad++; $display("FAIL two_advance_run got=%b want=0", run); end
    sample(8'h00);
    total++; if (run !== 1'b1) begin bad++; $display("FAIL two_fire_run got=%b want=1", run); end
    total++; if (stage !== 2'd1) begin bad++; $display("FAIL two_fire_stage got=%0d want=1", stage); end
  endtask

  task automatic test_first_sample();
    cfg_write(2'd0, 8'h00, 8'h00, 8'h08, 8'h00, 16'd0, 2'd0);
    arm_pulse();
    sample(8'h08);
    total++; if (run !== 1'b0) begin bad++; $display("FAIL first_sample_run got=%b want=0", run); end
    sample(8'h00);
    total++; if (run !== 1'b0) begin bad++; $display("FAIL first_low_run got=%b want=0", run); end
    sample(8'h08);
    total++; if (run !== 1'b1) begin bad++; $display("FAIL first_edge_run got=%b want=1", run); end
  endtask

  task automatic test_arm_priority();
    arm_pulse();
    sample(8'h00);
    arm    = 1'b1;
    valid  = 1'b1;
    dataIn = 8'h08;
    cyc();
    arm    = 1'b0;
    valid  = 1'b0;
    total++; if (run !== 1'b0) begin bad++; $display("FAIL prio_run got=%b want=0", run); end
    total++; if (triggered !== 1'b0) begin bad++; $display("FAIL prio_triggered got=%b want=0", triggered); end
    total++; if (armed !== 1'b1) begin bad++; $display("FAIL prio_armed got=%b want=1", armed); end
    total++; if (stage !== 2'd0) begin bad++; $display("FAIL prio_stage got=%0d want=0", stage); end
    cfg_write(2'd0, 8'hFF, 8'h00, 8'h00, 8'h00, 16'd0, 2'd1);
    sample(8'h00);
    total++; if (run !== 1'b0) begin bad++; $display("FAIL cfg_locked_run got=%b want=0", run); end
    sample(8'h08);
    total++; if (run !== 1'b1) begin bad++; $display("FAIL cfg_locked_fire got=%b want=1", run); end
    total++; if (stage !== 2'd0) begin bad++; $display("FAIL cfg_locked_stage got=%0d want=0", stage); end
  endtask

  task automatic test_run_hold();
    for (int i = 0; i < 5; i++) begin
      cyc();
      total++; if (run !== 1'b1) begin bad++; $display("FAIL hold_run cycle=%0d got=%b want=1", i, run); end
    end
    valid  = 1'b1;
    dataIn = 8'h00;
    total++; if (run !== 1'b1) begin bad++; $display("FAIL hold_with_valid got=%b want=1", run); end
    cyc();
    valid  = 1'b0;
    total++; if (run !== 1'b0) begin bad++; $display("FAIL hold_drop got=%b want=0", run); end
    total++; if (triggered !== 1'b1) begin bad++; $display("FAIL hold_sticky got=%b want=1", triggered); end
  endtask

  task automatic test_async_reset();
    cfg_write(2'd0, 8'h01, 8'h01, 8'h00, 8'h00, 16'd0, 2'd1);
    cfg_write(2'd1, 8'h00, 8'h00, 8'h00, 8'h01, 16'd0, 2'd1);
    arm_pulse();
    sample(8'h01);
    total++; if (stage !== 2'd1) begin bad++; $display("FAIL areset_pre_stage got=%0d want=1", stage); end
    #2 reset_n = 1'b0;
    #1;
    total++; if (armed !== 1'b0) begin bad++; $display("FAIL areset_armed got=%b want=0", armed); end
    total++; if (stage !== 2'd0) begin bad++; $display("FAIL areset_stage got=%0d want=0", stage); end
    total++; if (run !== 1'b0) begin bad++; $display("FAIL areset_run got=%b want=0", run); end
    total++; if (triggered !== 1'b0) begin bad++; $display("FAIL areset_triggered got=%b want=0", triggered); end
    @(negedge clock);
    reset_n = 1'b1;
    cyc();
    arm_pulse();
    sample(8'h5A);
    total++; if (run !== 1'b1) begin bad++; $display("FAIL areset_cfg_cleared_run got=%b want=1", run); end
    total++; if (stage !== 2'd0) begin bad++; $display("FAIL areset_cfg_cleared_stage got=%0d want=0", stage); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset_n = 1'b0;
    valid = 1'b0;
    dataIn = 8'h00;
    arm = 1'b0;
    cfg_we = 1'b0;
    cfg_stage = 2'd0;
    cfg_level_mask = 8'h00;
    cfg_level_value = 8'h00;
    cfg_rise = 8'h00;
    cfg_fall = 8'h00;
    cfg_count = 16'd0;
    cfg_last_stage = 2'd0;
`ifdef TRIGGER_SEQ_DELAY_EN
    cfg_delay = 16'd0;
`endif
    @(negedge clock);
    test_reset();
    test_level();
    test_rise_count();
    test_two_stage();
    test_first_sample();
    test_arm_priority();
    test_run_hold();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/trigger_sequencer.md
Name: trigger_sequencer

Overview:
Multi-stage, parametrised successor to the single-level basic trigger.
- Each stage has a per-channel level mask/value, rising-edge mask, falling-edge mask and an occurrence count.
- Stages are walked in order. When the last configured stage completes, the block asserts run to the capture controller.
- Sits between the sample pipeline (dataIn/valid) and the capture FSM, in place of the basic trigger.

Parameters:
SAMPLE_WIDTH, 8, channels per sample
STAGES, 4, number of sequential trigger stages (1..16)
COUNT_WIDTH, 16, width of per-stage occurrence counter

Ports:
clock  in  1  sample clock
reset_n  in  1  asynchronous active-low reset
valid  in  1  dataIn holds a new sample this cycle
dataIn  in  SAMPLE_WIDTH  current sample
arm  in  1  start/restart at stage 0
cfg_we  in  1  write one stage's configuration
cfg_stage  in  $clog2(STAGES) (min 1)  stage index written
cfg_level_mask  in  SAMPLE_WIDTH  1 = channel level compared
cfg_level_value  in  SAMPLE_WIDTH  required level for masked channels
cfg_rise  in  SAMPLE_WIDTH  1 = rising edge required on channel
cfg_fall  in  SAMPLE_WIDTH  1 = falling edge required on channel
cfg_count  in  COUNT_WIDTH  matches required minus 1
cfg_last_stage  in  $clog2(STAGES) (min 1)  index of final stage; latched on every cfg_we
armed  out  1  sequencer waiting for trigger
stage  out  $clog2(STAGES) (min 1)  current stage index
run  out  1  trigger fired
triggered  out  1  sticky: trigger fired since last arm

Behaviour:
- Reset (async assert, sync-safe deassert):
  - armed=0, stage=0, run=0, triggered=0.
  - All stage configs cleared.
  - last_stage=0, prev-sample valid flag cleared.
- FSM states: IDLE, ARMED, FIRED (package enum). Reset goes to IDLE.
- Any state + arm=1 -> ARMED:
  - stage=0, match counter=0, prev_ok=0, run=0, triggered=0.
  - arm has priority over every other event in the same cycle.
- Edge history:
  - prev_sample is updated on every valid cycle.
  - prev_ok is set after the first valid sample following arm.
  - Edge terms never match while prev_ok=0.
- Stage match (on a valid cycle, combinational, all terms ANDed):
  - (dataIn & level_mask) == (level_value & level_mask)
  - every cfg_rise channel: prev=0, now=1
  - every cfg_fall channel: prev=1, now=0
  - A channel with both rise and fall set matches either edge.
  - A stage with all masks zero matches any valid sample.
- ARMED, valid match:
  - count < stage count: increment count.
  - count reaches stage count: if stage == last_stage -> FIRED; else stage+1 and count=0.
  - Matches need not be consecutive.
- Non-valid cycles: no state change, no counting.
- Latency: matching sample at edge t -> run=1 and triggered=1 from edge t+1 (one register).
- run is held high until the first cycle with valid=1 after assertion, then cleared, so the capture side always sees it alongside a valid sample.
- FIRED: armed=0, stage holds the final index, and the block waits for arm.
- Configuration writes:
  - Accepted in IDLE/FIRED.
  - Silently ignored in ARMED.
  - cfg_stage >= STAGES is ignored.
  - cfg_last_stage >= STAGES is clamped to STAGES-1.
- Counter cannot wrap: cfg_count max value needs 2^COUNT_WIDTH matches; the comparison is equality.

Optional Feature:
Macro: TRIGGER_SEQ_DELAY_EN
- Defined:
  - Adds port cfg_delay (in, COUNT_WIDTH), latched on cfg_we, and a DELAY state between ARMED and FIRED.
  - On final match, enter DELAY. triggered=1 immediately.
  - run asserts after cfg_delay further valid samples. cfg_delay=0 behaves as if the macro were undefined.
  - arm during DELAY aborts to ARMED.
- Undefined: no cfg_delay port, no DELAY state; run timing as above.

Decomposition:
- trigger_pkg:
  - state enum trig_state_e (IDLE, ARMED, FIRED, DELAY)
  - localparam STAGE_IDX_W helper function (clog2, min 1)
- Sub-module trigger_stage_match: purely combinational. Takes one stage's masks plus dataIn/prev_sample/prev_ok/valid and outputs match.
- Top instantiates one matcher, fed by a mux of the current stage's configuration.

Test Plan:
- Single level stage, SAMPLE_WIDTH=8, stage0 mask=0xFF value=0xA5, last=0; arm, drive 0x00,0xA5 with valid -> run high the cycle after 0xA5, triggered sticky.
- Rising edge ch3, count=2; drive bit3 toggling 0->1 three times -> fires only on third edge, stage stays 0, count increments observed.
- Two stages: stage0 level 0x01, stage1 fall ch0; send 0x01 then 0x00 -> stage 0->1 then run; sending 0x00 first does nothing.
- First-sample edge rule: arm with dataIn=0x08 on first valid, rise ch3 -> no fire; next 0x00,0x08 -> fire.
- arm asserted same cycle as final match -> no run, stage=0, armed=1; cfg_we while armed leaves config unchanged.
- valid low for 5 cycles after trigger -> run stays high until next valid cycle, then drops; reset_n low mid-ARMED -> all outputs 0 immediately (async).
